mvm_seq_ctrl: RTL

//  Command sequencer in front of one mvm_<K>_<P>_<B>_<G> instance. Accepts ops plus valid/ready

---
 rtl/mvm_ctrl_pkg.sv | 23 ++
 rtl/mvm_seq_ctrl_if.sv | 41 ++++
 rtl/mvm_ctrl_buf.sv | 47 ++++
 rtl/mvm_seq_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mvm_ctrl_pkg.sv
// Shared types for the MVM command sequencer: op codes and FSM states.
package mvm_ctrl_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD_M = 2'd0,
    OP_LOAD_V = 2'd1,
    OP_RUN    = 2'd2
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_STREAM,
    S_START,
    S_WAIT,
    S_COLLECT,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/mvm_seq_ctrl_if.sv
// Host-side command/data/result streams plus the MVM control pins of the sequencer.
interface mvm_seq_ctrl_if
  import mvm_ctrl_pkg::*;
#(
  parameter int B = 8
);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OP_W-1:0] cmd_op;
  logic            s_valid;
  logic            s_ready;
  logic [B-1:0]    s_data;
  logic            m_valid;
  logic            m_ready;
  logic [2*B-1:0]  m_data;
  logic            m_last;
  logic            err;
  logic            busy;
  logic            mvm_loadM;
  logic            mvm_loadV;
  logic            mvm_start;
  logic [B-1:0]    mvm_din;
  logic            mvm_done;
  logic [2*B-1:0]  mvm_dout;

  // slave: the sequencer itself
  modport slave (
    input  cmd_valid, cmd_op, s_valid, s_data, m_ready, mvm_done, mvm_dout,
    output cmd_ready, s_ready, m_valid, m_data, m_last, err, busy,
           mvm_loadM, mvm_loadV, mvm_start, mvm_din
  );

  // master: host plus MVM side surrounding the sequencer
  modport master (
    output cmd_valid, cmd_op, s_valid, s_data, m_ready, mvm_done, mvm_dout,
    input  cmd_ready, s_ready, m_valid, m_data, m_last, err, busy,
           mvm_loadM, mvm_loadV, mvm_start, mvm_din
  );

endinterface

// File: rtl/mvm_ctrl_buf.sv
// Linear burst buffer: register array with independent write/read counters against a run-time length n.
module mvm_ctrl_buf #(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [CW-1:0] n,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          wr_last,
  output logic          rd_last
);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr_q;
  logic [CW-1:0] rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q[AW-1:0]];
  assign full    = (wr_ptr_q == n);
  assign wr_last = (wr_ptr_q == n - CW'(1));
  assign rd_last = (rd_ptr_q == n - CW'(1));

endmodule

// File: rtl/mvm_seq_ctrl.sv
// Command sequencer owning all MVM control pins: buffers load bursts, replays them gaplessly, collects results.
// Optional done watchdog enabled by defining MVM_CTRL_TIMEOUT_EN.
module mvm_seq_ctrl
  import mvm_ctrl_pkg::*;
#(
  parameter int K       = 4,
  parameter int B       = 8,
  parameter int TIMEOUT = 4*K*K + 16
) (
  input logic           clk,
  input logic           reset,
  mvm_seq_ctrl_if.slave bus
);

  localparam int NM  = K * K;
  localparam int ICW = $clog2(NM + 1);
  localparam int RCW = $clog2(K + 1);

  state_t state_q, state_d;
  logic m_loaded_q, m_loaded_d;
  logic v_loaded_q, v_loaded_d;
  logic is_m_q, is_m_d;
  logic err_q, err_d;
  logic cmd_ready_q;
  logic cmd_acc, timeout_hit;

  logic           in_clr, in_wr_en, in_rd_en, in_full, in_wr_last, in_rd_last;
  logic [B-1:0]   in_rd_data;
  logic [ICW-1:0] in_n;
  logic           res_clr, res_wr_en, res_rd_en, res_full, res_wr_last, res_rd_last;
  logic [2*B-1:0] res_rd_data;

  assign cmd_acc   = bus.cmd_valid & cmd_ready_q;
  assign in_n      = is_m_q ? ICW'(NM) : ICW'(K);
  assign in_wr_en  = (state_q == S_FILL) & bus.s_valid & ~in_full;
  assign in_rd_en  = (state_q == S_STREAM);
  assign res_wr_en = (state_q == S_COLLECT) & ~res_full;
  assign res_rd_en = (state_q == S_DRAIN) & bus.m_ready;

  mvm_ctrl_buf #(.DEPTH(NM), .W(B)) u_in_buf (
    .clk(clk), .rst(reset), .clr(in_clr),
    .wr_en(in_wr_en), .wr_data(bus.s_data), .rd_en(in_rd_en), .n(in_n),
    .rd_data(in_rd_data), .full(in_full), .wr_last(in_wr_last), .rd_last(in_rd_last)
  );

  mvm_ctrl_buf #(.DEPTH(K), .W(2*B)) u_res_buf (
    .clk(clk), .rst(reset), .clr(res_clr),
    .wr_en(res_wr_en), .wr_data(bus.mvm_dout), .rd_en(res_rd_en), .n(RCW'(K)),
    .rd_data(res_rd_data), .full(res_full), .wr_last(res_wr_last), .rd_last(res_rd_last)
  );

`ifdef MVM_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wd_q <= '0;
    else if (state_q != S_WAIT) wd_q <= '0;
    else                        wd_q <= wd_q + WDW'(1);
  end

  // fires on the TIMEOUT-th WAIT cycle; a done in that same cycle still wins
  assign timeout_hit = (state_q == S_WAIT) & (wd_q == WDW'(TIMEOUT - 1));
`else
  if (TIMEOUT >= 1) begin : g_no_wd
    assign timeout_hit = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    m_loaded_d = m_loaded_q;
    v_loaded_d = v_loaded_q;
    is_m_d     = is_m_q;
    err_d      = 1'b0;
    in_clr     = 1'b0;
    res_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          case (bus.cmd_op)
            OP_LOAD_M: begin is_m_d = 1'b1; in_clr = 1'b1; state_d = S_FILL; end
            OP_LOAD_V: begin is_m_d = 1'b0; in_clr = 1'b1; state_d = S_FILL; end
            OP_RUN: begin
              if (m_loaded_q & v_loaded_q) begin
                res_clr = 1'b1;
                state_d = S_START;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_FILL:   if (in_wr_en & in_wr_last) state_d = S_ISSUE;
      S_ISSUE:  state_d = S_STREAM;
      S_STREAM: begin
        if (in_rd_last) begin
          in_clr  = 1'b1;
          state_d = S_IDLE;
          // a new matrix invalidates the vector previously paired with it
          if (is_m_q) begin m_loaded_d = 1'b1; v_loaded_d = 1'b0; end
          else        v_loaded_d = 1'b1;
        end
      end
      S_START:  state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mvm_done) begin
          state_d = S_COLLECT;
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          m_loaded_d = 1'b0;
          v_loaded_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_COLLECT: if (res_wr_last) state_d = S_DRAIN;
      S_DRAIN: begin
        if (res_rd_en & res_rd_last) begin
          res_clr = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      m_loaded_q  <= 1'b0;
      v_loaded_q  <= 1'b0;
      is_m_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_loaded_q  <= m_loaded_d;
      v_loaded_q  <= v_loaded_d;
      is_m_q      <= is_m_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == S_IDLE);
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.s_ready   = (state_q == S_FILL);
  assign bus.m_valid   = (state_q == S_DRAIN);
  assign bus.m_data    = (state_q == S_DRAIN) ? res_rd_data : '0;
  assign bus.m_last    = (state_q == S_DRAIN) & res_rd_last;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mvm_loadM = (state_q == S_ISSUE) & is_m_q;
  assign bus.mvm_loadV = (state_q == S_ISSUE) & ~is_m_q;
  assign bus.mvm_start = (state_q == S_START);
  assign bus.mvm_din   = (state_q == S_STREAM) ? in_rd_data : '0;

endmodule
